// File: rtl/reg_write_pulse_gen_if.sv
// Request/strobe bundle for reg_write_pulse_gen.
// The master side (register decode) drives the requests and overflow clears.
// The slave side (the pulse generator) returns the strobes and status flags.
interface reg_write_pulse_gen_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] wtite;
  logic [CHANNELS-1:0] ovf_clr;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] overflow;

  modport master (
    output wtite,
    output ovf_clr,
    input  pulse,
    input  busy,
    input  overflow
  );

  modport slave (
    input  wtite,
    input  ovf_clr,
    output pulse,
    output busy,
    output overflow
  );
endinterface

// File: rtl/reg_write_pulse_gen.sv
// Multi-channel register write-strobe generator.
// Each channel turns a write request into a PULSE_LEN-cycle strobe, then holds
// at least GAP_LEN idle cycles. One request per channel can wait while a strobe
// or gap is in progress; further requests are dropped and, in edge mode,
// flagged on a sticky overflow bit.
module reg_write_pulse_gen #(
  parameter int CHANNELS  = 4,
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 1,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_write_pulse_gen_if.slave   bus
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);

  // Counters hold "cycles remaining minus one", so a phase ends when they hit 0.
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              state   [CHANNELS];
  logic [CW-1:0]       cnt     [CHANNELS];
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] busy_q;
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] wtite_q;
  logic [CHANNELS-1:0] req;

  // Request qualification: a rising edge in edge mode, the raw level otherwise.
  assign req = EDGE_MODE ? (bus.wtite & ~wtite_q) : bus.wtite;

  assign bus.pulse    = pulse_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

  // Previous request level; sampled through reset so a level held across
  // reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    wtite_q <= bus.wtite;
  end

  // Per-channel strobe FSM with its counter, pending slot and status flags.
  // NOTE: every register here uses <= so all channels see the same pre-edge
  // values; a later <= to the same bit in this block overrides an earlier one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      pulse_q <= '0;
      busy_q  <= '0;
      ovf_q   <= '0;
      // NOTE: the per-channel state/counter arrays are a handful of flops, not
      // a RAM, so they are cleared explicitly like any other register.
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        // Clear first so a same-cycle overflow event below takes priority.
        if (bus.ovf_clr[i]) begin
          ovf_q[i] <= 1'b0;
        end

        case (state[i])
          ST_IDLE: begin
            if (req[i]) begin
              state[i]   <= ST_PULSE;
              cnt[i]     <= PULSE_LOAD;
              pulse_q[i] <= 1'b1;
              busy_q[i]  <= 1'b1;
            end
          end

          ST_PULSE: begin
            busy_q[i] <= 1'b1;
            if (cnt[i] == '0) begin
              state[i]   <= ST_GAP;
              cnt[i]     <= GAP_LOAD;
              pulse_q[i] <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] - CNT_ONE;
            end
            if (req[i]) begin
              if (!pending[i]) begin
                pending[i] <= 1'b1;
              end else if (EDGE_MODE) begin
                ovf_q[i] <= 1'b1;
              end
            end
          end

          ST_GAP: begin
            if (cnt[i] == '0) begin
              // Last gap cycle: the waiting request goes first and a new
              // request arriving now takes over the freed pending slot.
              pending[i] <= pending[i] & req[i];
              if (pending[i] | req[i]) begin
                state[i]   <= ST_PULSE;
                cnt[i]     <= PULSE_LOAD;
                pulse_q[i] <= 1'b1;
                busy_q[i]  <= 1'b1;
              end else begin
                state[i]  <= ST_IDLE;
                busy_q[i] <= 1'b0;
              end
            end else begin
              cnt[i]    <= cnt[i] - CNT_ONE;
              busy_q[i] <= 1'b1;
              if (req[i]) begin
                if (!pending[i]) begin
                  pending[i] <= 1'b1;
                end else if (EDGE_MODE) begin
                  ovf_q[i] <= 1'b1;
                end
              end
            end
          end

          default: begin
            state[i]   <= ST_IDLE;
            cnt[i]     <= '0;
            pulse_q[i] <= 1'b0;
            busy_q[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_write_pulse_gen.sv
// Directed testbench for reg_write_pulse_gen.
// Two instances share the clock: dut_a in edge mode, dut_b in level mode, both
// with PULSE_LEN=3, GAP_LEN=2. Cycle c of a scenario is the interval around
// negedge c after its reset; inputs set there are sampled by the next posedge,
// so a request in cycle c shows up as a strobe in cycle c+1.
module tb_reg_write_pulse_gen;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int checks = 0;
  int errors = 0;

  reg_write_pulse_gen_if #(.CHANNELS(CH)) if_a ();
  reg_write_pulse_gen_if #(.CHANNELS(CH)) if_b ();

  reg_write_pulse_gen #(
    .CHANNELS (CH),
    .PULSE_LEN(3),
    .GAP_LEN  (2),
    .EDGE_MODE(1'b1)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(if_a.slave)
  );

  reg_write_pulse_gen #(
    .CHANNELS (CH),
    .PULSE_LEN(3),
    .GAP_LEN  (2),
    .EDGE_MODE(1'b0)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(if_b.slave)
  );

  always #5 clk = ~clk;

  // Reset both instances with all requests low; returns on the negedge just
  // before the first non-reset posedge.
  task automatic do_reset();
    @(negedge clk);
    rst_a        = 1'b1;
    rst_b        = 1'b1;
    if_a.wtite   = '0;
    if_a.ovf_clr = '0;
    if_b.wtite   = '0;
    if_b.ovf_clr = '0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (if_a.pulse !== 4'b0000 || if_a.busy !== 4'b0000 || if_a.overflow !== 4'b0000) begin
      errors++;
      $display("FAIL reset_a got p=%b b=%b o=%b exp all 0000", if_a.pulse, if_a.busy, if_a.overflow);
    end
    checks++;
    if (if_b.pulse !== 4'b0000 || if_b.busy !== 4'b0000 || if_b.overflow !== 4'b0000) begin
      errors++;
      $display("FAIL reset_b got p=%b b=%b o=%b exp all 0000", if_b.pulse, if_b.busy, if_b.overflow);
    end
  endtask

  // One request on ch0 at cycle 10.
  task automatic test_single();
    logic [CH-1:0] ep, eb;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      ep = {3'b000, (c >= 11 && c <= 13)};
      eb = {3'b000, (c >= 11 && c <= 15)};
      checks++;
      if (if_a.pulse !== ep) begin
        errors++; $display("FAIL single_pulse cyc=%0d got=%b exp=%b", c, if_a.pulse, ep);
      end
      checks++;
      if (if_a.busy !== eb) begin
        errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, if_a.busy, eb);
      end
      checks++;
      if (if_a.overflow !== 4'b0000) begin
        errors++; $display("FAIL single_ovf cyc=%0d got=%b exp=0000", c, if_a.overflow);
      end
      if_a.wtite = {3'b000, (c == 10)};
    end
  endtask

  // Second edge during the strobe is held pending and served after the gap.
  task automatic test_pending();
    logic [CH-1:0] ep, eb;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      ep = {3'b000, ((c >= 11 && c <= 13) || (c >= 16 && c <= 18))};
      eb = {3'b000, (c >= 11 && c <= 20)};
      checks++;
      if (if_a.pulse !== ep) begin
        errors++; $display("FAIL pend_pulse cyc=%0d got=%b exp=%b", c, if_a.pulse, ep);
      end
      checks++;
      if (if_a.busy !== eb) begin
        errors++; $display("FAIL pend_busy cyc=%0d got=%b exp=%b", c, if_a.busy, eb);
      end
      checks++;
      if (if_a.overflow !== 4'b0000) begin
        errors++; $display("FAIL pend_ovf cyc=%0d got=%b exp=0000", c, if_a.overflow);
      end
      if_a.wtite = {3'b000, (c == 10 || c == 12)};
    end
  endtask

  // Third edge overflows; clear at 22; a clear coinciding with a new
  // overflow event at 34 leaves the flag set.
  task automatic test_overflow();
    logic [CH-1:0] ep, eb, eo;
    do_reset();
    for (int c = 0; c <= 42; c++) begin
      @(negedge clk);
      ep = {3'b000, ((c >= 11 && c <= 13) || (c >= 16 && c <= 18) ||
                     (c >= 31 && c <= 33) || (c >= 36 && c <= 38))};
      eb = {3'b000, ((c >= 11 && c <= 20) || (c >= 31 && c <= 40))};
      eo = {3'b000, ((c >= 15 && c <= 22) || c >= 35)};
      checks++;
      if (if_a.pulse !== ep) begin
        errors++; $display("FAIL ovf_pulse cyc=%0d got=%b exp=%b", c, if_a.pulse, ep);
      end
      checks++;
      if (if_a.busy !== eb) begin
        errors++; $display("FAIL ovf_busy cyc=%0d got=%b exp=%b", c, if_a.busy, eb);
      end
      checks++;
      if (if_a.overflow !== eo) begin
        errors++; $display("FAIL ovf_flag cyc=%0d got=%b exp=%b", c, if_a.overflow, eo);
      end
      if_a.wtite   = {3'b000, (c == 10 || c == 12 || c == 14 || c == 30 || c == 32 || c == 34)};
      if_a.ovf_clr = {3'b000, (c == 22 || c == 34)};
    end
  endtask

  // Level mode: ch1 held high 10..24 gives back-to-back strobes, never overflow.
  task automatic test_level_mode();
    logic [CH-1:0] ep, eb;
    do_reset();
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      ep = {2'b00, ((c >= 11 && c <= 13) || (c >= 16 && c <= 18) ||
                    (c >= 21 && c <= 23) || (c >= 26 && c <= 28)), 1'b0};
      eb = {2'b00, (c >= 11 && c <= 30), 1'b0};
      checks++;
      if (if_b.pulse !== ep) begin
        errors++; $display("FAIL level_pulse cyc=%0d got=%b exp=%b", c, if_b.pulse, ep);
      end
      checks++;
      if (if_b.busy !== eb) begin
        errors++; $display("FAIL level_busy cyc=%0d got=%b exp=%b", c, if_b.busy, eb);
      end
      checks++;
      if (if_b.overflow !== 4'b0000) begin
        errors++; $display("FAIL level_ovf cyc=%0d got=%b exp=0000", c, if_b.overflow);
      end
      if_b.wtite = {2'b00, (c >= 10 && c <= 24), 1'b0};
    end
  endtask

  // Reset mid-strobe with the request level held across reset release.
  task automatic test_mid_pulse_reset();
    logic [CH-1:0] ep, eb;
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      ep = {3'b000, (c >= 11 && c <= 12)};
      eb = {3'b000, (c >= 11 && c <= 12)};
      checks++;
      if (if_a.pulse !== ep) begin
        errors++; $display("FAIL rst_pulse cyc=%0d got=%b exp=%b", c, if_a.pulse, ep);
      end
      checks++;
      if (if_a.busy !== eb) begin
        errors++; $display("FAIL rst_busy cyc=%0d got=%b exp=%b", c, if_a.busy, eb);
      end
      checks++;
      if (if_a.overflow !== 4'b0000) begin
        errors++; $display("FAIL rst_ovf cyc=%0d got=%b exp=0000", c, if_a.overflow);
      end
      if_a.wtite = {3'b000, (c >= 10)};
      rst_a      = (c == 12);
    end
    @(negedge clk);
    if_a.wtite = '0;
  endtask

  // Independent channels: ch0 and ch3 together, ch3 again during its gap.
  task automatic test_multi_channel();
    logic [CH-1:0] ep, eb;
    logic          p0, p3, b0, b3;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      p0 = (c >= 11 && c <= 13);
      p3 = (c >= 11 && c <= 13) || (c >= 16 && c <= 18);
      b0 = (c >= 11 && c <= 15);
      b3 = (c >= 11 && c <= 20);
      ep = {p3, 2'b00, p0};
      eb = {b3, 2'b00, b0};
      checks++;
      if (if_a.pulse !== ep) begin
        errors++; $display("FAIL multi_pulse cyc=%0d got=%b exp=%b", c, if_a.pulse, ep);
      end
      checks++;
      if (if_a.busy !== eb) begin
        errors++; $display("FAIL multi_busy cyc=%0d got=%b exp=%b", c, if_a.busy, eb);
      end
      checks++;
      if (if_a.overflow !== 4'b0000) begin
        errors++; $display("FAIL multi_ovf cyc=%0d got=%b exp=0000", c, if_a.overflow);
      end
      if_a.wtite = {(c == 10 || c == 14), 2'b00, (c == 10)};
    end
  endtask

  initial begin
    rst_a        = 1'b1;
    rst_b        = 1'b1;
    if_a.wtite   = '0;
    if_a.ovf_clr = '0;
    if_b.wtite   = '0;
    if_b.ovf_clr = '0;

    test_reset();
    test_single();
    test_pending();
    test_overflow();
    test_level_mode();
    test_mid_pulse_reset();
    test_multi_channel();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
